// File: rtl/sseg_scan_decoder.sv
// Rebuilds per-digit BCD values and decimal points from a scanned active-low seven-segment bus.
// Latency: outputs move on the commit edge, STABLE_CYCLES+3 edges after the bus settles; no backpressure.
module sseg_scan_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              sseg_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    changed,
    output logic                    multi_en,
    output logic                    code_err
);

    localparam int BW = 8 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [BW-1:0]           s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [CW-1:0]           stable_cnt_q, stable_cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d, valid_q, valid_d, seen_q, seen_d;
    logic                    frame_done_q, frame_done_d, changed_q, changed_d;
    logic                    multi_en_q, multi_en_d, code_err_q, code_err_d;

    logic                    same, commit, dec_ok;
    logic [3:0]              dec_val;
    logic [7:0]              bus_sseg;
    logic [NUM_DIGITS-1:0]   en_mask;

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'hE;
        case (bus_sseg[6:0])
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: dec_val = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        s1_d     = {sseg_in, en_in};
        s2_d     = s1_q;
        prev_d   = s2_q;
        bus_sseg = s2_q[BW-1 -: 8];
        en_mask  = ~s2_q[NUM_DIGITS-1:0];
        same     = (s2_q == prev_q);

        if (!same)
            stable_cnt_d = '0;
        else if (stable_cnt_q == CW'(STABLE_CYCLES))
            stable_cnt_d = stable_cnt_q;
        else
            stable_cnt_d = stable_cnt_q + 1'b1;

        // One commit per stable period: the counter only passes this value once
        commit = same && (stable_cnt_q == CW'(STABLE_CYCLES - 1));

        digits_d     = digits_q;
        dp_d         = dp_q;
        valid_d      = valid_q;
        seen_d       = seen_q;
        frame_done_d = 1'b0;
        changed_d    = 1'b0;
        multi_en_d   = 1'b0;
        code_err_d   = 1'b0;

        if (commit && (en_mask != '0)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (en_mask[i]) begin
                    digits_d[4*i +: 4] = dec_val;
                    dp_d[i]            = ~bus_sseg[7];
                    valid_d[i]         = dec_ok;
                end
            end
            changed_d    = ({digits_d, dp_d} != {digits_q, dp_q});
            multi_en_d   = ($countones(en_mask) > 1);
            code_err_d   = ~dec_ok;
            frame_done_d = &(seen_q | en_mask);
            seen_d       = frame_done_d ? '0 : (seen_q | en_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '1;
            s2_q         <= '1;
            prev_q       <= '1;
            stable_cnt_q <= '0;
            digits_q     <= '1;
            dp_q         <= '0;
            valid_q      <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
            multi_en_q   <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            prev_q       <= prev_d;
            stable_cnt_q <= stable_cnt_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            valid_q      <= valid_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            changed_q    <= changed_d;
            multi_en_q   <= multi_en_d;
            code_err_q   <= code_err_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign changed     = changed_q;
    assign multi_en    = multi_en_q;
    assign code_err    = code_err_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: vector table, hand-written corner sequences, and random bus
// traffic checked every cycle against a bus-history reference model.
module tb_sseg_scan_decoder;

    localparam int ST = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sseg_in;
    logic [5:0]  en_in;
    logic [23:0] digits;
    logic [5:0]  dp, digit_valid;
    logic        frame_done, changed, multi_en, code_err;

    sseg_scan_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .sseg_in(sseg_in), .en_in(en_in),
        .digits(digits), .dp(dp), .digit_valid(digit_valid),
        .frame_done(frame_done), .changed(changed), .multi_en(multi_en), .code_err(code_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a committed value is one the bus held for ST+1 consecutive samples,
    // seen by the outputs two edges after the run completes (synchroniser delay).
    logic [6:0]  pats [10];
    logic [13:0] hist [20];
    logic [23:0] m_digits;
    logic [5:0]  m_dp, m_valid, m_seen;
    logic        m_frame, m_chg, m_multi, m_err;

    function automatic logic [4:0] ref_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = {1'b0, 4'hE};
        if (seg == 7'h7F) r = {1'b1, 4'hF};
        for (int k = 0; k < 10; k++)
            if (seg == pats[k]) r = {1'b1, 4'(k)};
        return r;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 20; j++) hist[j] = 14'h3FFF;
        m_digits = 24'hFFFFFF; m_dp = '0; m_valid = '0; m_seen = '0;
        {m_frame, m_chg, m_multi, m_err} = '0;
    endtask

    task automatic model_edge(input logic [7:0] s, input logic [5:0] e);
        logic        commit;
        logic [4:0]  dec;
        logic [5:0]  mask;
        logic [23:0] nd;
        logic [5:0]  ndp;
        for (int j = 19; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = {s, e};
        commit = (hist[19] != hist[18]);
        for (int j = 2; j < 18; j++)
            if (hist[j] != hist[18]) commit = 1'b0;
        {m_frame, m_chg, m_multi, m_err} = '0;
        mask = ~hist[2][5:0];
        if (commit && mask != 6'h00) begin
            dec = ref_decode(hist[2][12:6]);
            nd  = m_digits;
            ndp = m_dp;
            for (int i = 0; i < 6; i++) begin
                if (mask[i]) begin
                    nd[4*i +: 4] = dec[3:0];
                    ndp[i]       = ~hist[2][13];
                    m_valid[i]   = dec[4];
                end
            end
            m_chg    = ({nd, ndp} != {m_digits, m_dp});
            m_multi  = ($countones(mask) > 1);
            m_err    = ~dec[4];
            m_frame  = ((m_seen | mask) == 6'h3F);
            m_seen   = m_frame ? 6'h00 : (m_seen | mask);
            m_digits = nd;
            m_dp     = ndp;
        end
    endtask

    int chg_cnt, err_cnt, multi_cnt, frame_cnt, step_idx, first_chg;

    task automatic clr_cnt();
        chg_cnt = 0; err_cnt = 0; multi_cnt = 0; frame_cnt = 0; step_idx = 0; first_chg = 0;
    endtask

    task automatic check_all();
        chk("digits", 32'(digits), 32'(m_digits));
        chk("dp", 32'(dp), 32'(m_dp));
        chk("digit_valid", 32'(digit_valid), 32'(m_valid));
        chk("changed", 32'(changed), 32'(m_chg));
        chk("multi_en", 32'(multi_en), 32'(m_multi));
        chk("code_err", 32'(code_err), 32'(m_err));
        chk("frame_done", 32'(frame_done), 32'(m_frame));
        step_idx++;
        if (changed === 1'b1) begin
            chg_cnt++;
            if (first_chg == 0) first_chg = step_idx;
        end
        if (code_err === 1'b1)   err_cnt++;
        if (multi_en === 1'b1)   multi_cnt++;
        if (frame_done === 1'b1) frame_cnt++;
    endtask

    task automatic step(input logic [7:0] s, input logic [5:0] e);
        @(negedge clk);
        sseg_in = s;
        en_in   = e;
        @(posedge clk);
        model_edge(s, e);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [7:0] s, input logic [5:0] e, input int n);
        for (int k = 0; k < n; k++) step(s, e);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_digits", 32'(digits), 32'h00FFFFFF);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [5:0]  en;
        logic [7:0]  sseg;
        logic [23:0] exp_digits;
        logic [5:0]  exp_dp;
        logic [5:0]  exp_valid;
        int          exp_multi;
        int          exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rs;
        logic [5:0] re;
        int         rn, r;

        pats = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        vecs[0] = '{6'b111110, 8'b10100100, 24'hFFFFF2, 6'b000000, 6'b000001, 0, 0};
        vecs[1] = '{6'b111100, 8'b01111001, 24'hFFFF11, 6'b000011, 6'b000011, 1, 0};
        vecs[2] = '{6'b111101, 8'b11111110, 24'hFFFFE1, 6'b000001, 6'b000001, 0, 1};
        vecs[3] = '{6'b111111, 8'b00000000, 24'hFFFFE1, 6'b000001, 6'b000001, 0, 0};
        vecs[4] = '{6'b000000, 8'b11111111, 24'hFFFFFF, 6'b000000, 6'b111111, 1, 0};

        rst_n   = 1'b0;
        sseg_in = 8'hFF;
        en_in   = 6'h3F;
        model_reset();
        clr_cnt();
        repeat (3) @(posedge clk);
        #1;
        chk("init_digits", 32'(digits), 32'h00FFFFFF);
        chk("init_dp", 32'(dp), 32'h0);
        chk("init_valid", 32'(digit_valid), 32'h0);
        chk("init_pulses", 32'({frame_done, changed, multi_en, code_err}), 32'h0);
        #1 rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            clr_cnt();
            hold(vecs[v].sseg, vecs[v].en, 30);
            chk("vec_digits", 32'(digits), 32'(vecs[v].exp_digits));
            chk("vec_dp", 32'(dp), 32'(vecs[v].exp_dp));
            chk("vec_valid", 32'(digit_valid), 32'(vecs[v].exp_valid));
            chk("vec_multi_cnt", 32'(multi_cnt), 32'(vecs[v].exp_multi));
            chk("vec_err_cnt", 32'(err_cnt), 32'(vecs[v].exp_err));
        end

        // Commit latency: changed lands exactly ST+3 edges after the bus settles
        apply_reset();
        clr_cnt();
        hold(8'b10100100, 6'b111110, 40);
        chk("lat_first_chg", 32'(first_chg), 32'(ST + 3));
        chk("lat_chg_cnt", 32'(chg_cnt), 32'd1);
        chk("lat_digit0", 32'(digits[3:0]), 32'd2);

        // Full scan: frame completes on the sixth commit only
        apply_reset();
        clr_cnt();
        for (int d = 0; d < 6; d++) begin
            logic [5:0] e;
            e = ~(6'b1 << d);
            hold({1'b1, pats[d]}, e, 30);
            if (d == 4) chk("scan_no_early_frame", 32'(frame_cnt), 32'd0);
        end
        chk("scan_digits", 32'(digits), 32'h00543210);
        chk("scan_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("scan_valid", 32'(digit_valid), 32'h3F);

        // Short glitch of another value must be ignored
        apply_reset();
        hold({1'b1, pats[5]}, 6'b111110, 30);
        clr_cnt();
        hold({1'b1, pats[6]}, 6'b111110, 10);
        hold({1'b1, pats[5]}, 6'b111110, 30);
        chk("glitch_digit0", 32'(digits[3:0]), 32'd5);
        chk("glitch_pulses", 32'(chg_cnt + err_cnt + multi_cnt + frame_cnt), 32'd0);

        // Reset mid-way through a stable period discards it
        hold({1'b1, pats[1]}, 6'b111110, 13);
        apply_reset();
        chk("midrst_digits", 32'(digits), 32'h00FFFFFF);
        clr_cnt();
        hold({1'b1, pats[1]}, 6'b111110, ST + 2);
        chk("midrst_no_commit", 32'(chg_cnt), 32'd0);
        step({1'b1, pats[1]}, 6'b111110);
        chk("midrst_commit", 32'(chg_cnt), 32'd1);
        chk("midrst_digit0", 32'(digits[3:0]), 32'd1);

        // Random bus traffic, held for lengths clustered around the stability threshold
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      re = 6'h3F;
            else if (r < 60) re = ~(6'b1 << $urandom_range(0, 5));
            else             re = 6'($urandom);
            r = $urandom_range(0, 99);
            if (r < 60)      rs = {1'($urandom), pats[$urandom_range(0, 9)]};
            else if (r < 75) rs = {1'($urandom), 7'h7F};
            else             rs = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rn = $urandom_range(ST - 1, ST + 3);
            else                           rn = $urandom_range(1, 40);
            hold(rs, re, rn);
            if (t == 75) apply_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
